// File: rtl/uart_receiver.sv
// 8E1 UART receiver with 16x oversampling, per-frame baud latching and
// registered data/valid/parity/framing outputs.
module uart_receiver #(
  parameter int unsigned CLK_FREQ = 32'd50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       RX_EN,
  input  logic       RxD,
  output logic [7:0] Rx_DATA,
  output logic       Rx_VALID,
  output logic       Rx_PERROR,
  output logic       Rx_FERROR
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  // Rounded clock cycles per 16x oversampling tick for a given rate code.
  function automatic logic [15:0] divisor_for(input logic [2:0] code);
    logic [31:0] baud;
    case (code)
      3'd0:    baud = 32'd300;
      3'd1:    baud = 32'd1200;
      3'd2:    baud = 32'd4800;
      3'd3:    baud = 32'd9600;
      3'd4:    baud = 32'd19200;
      3'd5:    baud = 32'd38400;
      3'd6:    baud = 32'd57600;
      3'd7:    baud = 32'd115200;
      default: baud = 32'd115200;
    endcase
    return 16'((CLK_FREQ + (baud << 3)) / (baud << 4));
  endfunction

  state_e      state_q, state_d;
  logic        rxd_meta_q, rxd_sync_q, rxd_prev_q;
  logic [15:0] div_q, div_d;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic [3:0]  tick_cnt_q, tick_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        perr_q, perr_d;
  logic        ferr_q, ferr_d;

  logic        fall_s;
  logic        tick_s;
  logic        sample_s;
  logic        frame_bad_s;

  assign fall_s      = rxd_prev_q & ~rxd_sync_q;
  assign tick_s      = (baud_cnt_q == (div_q - 16'd1));
  // Eighth tick of each 16-tick bit window lands on the bit midpoint.
  assign sample_s    = tick_s && (tick_cnt_q == 4'd7);
  assign frame_bad_s = (^{shift_q, par_q}) | ~rxd_sync_q;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      rxd_meta_q <= RxD;
      rxd_sync_q <= rxd_meta_q;
      rxd_prev_q <= rxd_sync_q;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      div_q      <= 16'd1;
      baud_cnt_q <= 16'd0;
      tick_cnt_q <= 4'd0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'd0;
      par_q      <= 1'b0;
      data_q     <= 8'd0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      baud_cnt_q <= baud_cnt_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    baud_cnt_d = 16'd0;
    tick_cnt_d = 4'd0;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    perr_d     = perr_q;
    ferr_d     = ferr_q;

    if (state_q != IDLE) begin
      baud_cnt_d = tick_s ? 16'd0 : (baud_cnt_q + 16'd1);
      tick_cnt_d = tick_s ? (tick_cnt_q + 4'd1) : tick_cnt_q;
    end else begin
      baud_cnt_d = 16'd0;
      tick_cnt_d = 4'd0;
    end

    if (!RX_EN) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (fall_s) begin
            state_d   = START;
            div_d     = divisor_for(baud_select);
            bit_cnt_d = 3'd0;
          end else begin
            state_d = IDLE;
          end
        end
        START: begin
          // Flags clear only once the start bit is confirmed, so a glitch
          // leaves every output untouched.
          if (sample_s && rxd_sync_q) begin
            state_d = IDLE;
          end else if (sample_s) begin
            state_d = DATA;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
          end else begin
            state_d = START;
          end
        end
        DATA: begin
          if (sample_s) begin
            shift_d   = {rxd_sync_q, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            state_d   = (bit_cnt_q == 3'd7) ? PARITY : DATA;
          end else begin
            state_d = DATA;
          end
        end
        PARITY: begin
          if (sample_s) begin
            par_d   = rxd_sync_q;
            state_d = STOP;
          end else begin
            state_d = PARITY;
          end
        end
        STOP: begin
          if (sample_s) begin
            perr_d  = ^{shift_q, par_q};
            ferr_d  = ~rxd_sync_q;
            data_d  = frame_bad_s ? data_q : shift_q;
            valid_d = ~frame_bad_s;
            state_d = IDLE;
          end else begin
            state_d = STOP;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign Rx_DATA   = data_q;
  assign Rx_VALID  = valid_q;
  assign Rx_PERROR = perr_q;
  assign Rx_FERROR = ferr_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Randomised self-checking bench for uart_receiver: drives 8E1 frames on RxD
// and compares against a frame-level reference model.
module tb_uart_receiver;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] baud_select;
  logic       RX_EN;
  logic       RxD;
  logic [7:0] Rx_DATA;
  logic       Rx_VALID;
  logic       Rx_PERROR;
  logic       Rx_FERROR;

  uart_receiver #(.CLK_FREQ(32'd50000000)) dut (
    .clk(clk), .reset(reset), .baud_select(baud_select), .RX_EN(RX_EN), .RxD(RxD),
    .Rx_DATA(Rx_DATA), .Rx_VALID(Rx_VALID), .Rx_PERROR(Rx_PERROR), .Rx_FERROR(Rx_FERROR)
  );

  always #10 clk = ~clk;

  int total = 0;
  int bad = 0;

  int div_tab[8] = '{10417, 2604, 651, 326, 163, 81, 54, 27};

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] exp_data;
  logic       exp_perr;
  logic       exp_ferr;
  int         dbl_valid = 0;
  logic       prev_v = 1'b0;

  // Collect every Rx_VALID pulse and note any pulse longer than one cycle.
  always @(negedge clk) begin
    if (Rx_VALID) rx_q.push_back(Rx_DATA);
    if (Rx_VALID && prev_v) dbl_valid <= dbl_valid + 1;
    prev_v <= Rx_VALID;
  end

  function automatic int bit_cycles(input int code);
    return div_tab[code] * 16;
  endfunction

  // Frame-level reference: a frame is good when data+parity has even weight and stop is 1.
  function automatic void model_frame(input logic [7:0] d, input logic p, input logic s);
    logic pe;
    pe = ^{d, p};
    exp_perr = pe;
    exp_ferr = ~s;
    if (!pe && s) begin
      exp_data = d;
      exp_q.push_back(d);
    end
  endfunction

  function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic p, input logic s);
    return {s, p, d, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int first, input int last, input int bc);
    for (int i = first; i <= last; i++) begin
      RxD = bits[i];
      repeat (bc) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    RxD = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    RxD = 1'b1;
    RX_EN = 1'b1;
    baud_select = 3'd7;
    exp_data = 8'h00; exp_perr = 1'b0; exp_ferr = 1'b0;
    #100;
    total++;
    if ({Rx_DATA, Rx_PERROR, Rx_FERROR, Rx_VALID} !== 11'd0) begin
      bad++;
      $display("FAIL reset_outputs: got data=%h pe=%b fe=%b v=%b want all zero", Rx_DATA, Rx_PERROR, Rx_FERROR, Rx_VALID);
    end
    @(negedge clk);
    reset = 1'b0;
    idle(20 * bit_cycles(7));
    total++;
    if (rx_q.size() != 0 || {Rx_DATA, Rx_PERROR, Rx_FERROR} !== 10'd0) begin
      bad++;
      $display("FAIL reset_idle: got pulses=%0d data=%h pe=%b fe=%b want 0 pulses, all zero", rx_q.size(), Rx_DATA, Rx_PERROR, Rx_FERROR);
    end
    rx_q.delete();
  endtask

  task automatic test_good_frame();
    int bc = bit_cycles(7);
    send_bits(frame_bits(8'hA5, 1'b0, 1'b1), 0, 10, bc);
    model_frame(8'hA5, 1'b0, 1'b1);
    idle(20);
    total++;
    if ({Rx_DATA, Rx_PERROR, Rx_FERROR} !== {exp_data, exp_perr, exp_ferr}) begin
      bad++;
      $display("FAIL good_outputs: got data=%h pe=%b fe=%b want data=%h pe=%b fe=%b", Rx_DATA, Rx_PERROR, Rx_FERROR, exp_data, exp_perr, exp_ferr);
    end
    total++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin
      bad++;
      $display("FAIL good_pulse: got pulses=%0d first=%h want 1 pulse of a5", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
    end
    rx_q.delete(); exp_q.delete();
  endtask

  task automatic test_parity_error();
    int bc = bit_cycles(7);
    logic [7:0] d;
    send_bits(frame_bits(8'hA5, 1'b1, 1'b1), 0, 10, bc);
    model_frame(8'hA5, 1'b1, 1'b1);
    idle(20);
    total++;
    if ({Rx_DATA, Rx_PERROR, Rx_FERROR, rx_q.size() == 0} !== {exp_data, exp_perr, exp_ferr, 1'b1}) begin
      bad++;
      $display("FAIL parity_err: got data=%h pe=%b fe=%b pulses=%0d want data=%h pe=%b fe=%b pulses=0", Rx_DATA, Rx_PERROR, Rx_FERROR, rx_q.size(), exp_data, exp_perr, exp_ferr);
    end
    d = 8'($urandom);
    send_bits(frame_bits(d, ^d, 1'b1), 0, 10, bc);
    model_frame(d, ^d, 1'b1);
    idle(20);
    total++;
    if ({Rx_DATA, Rx_PERROR, Rx_FERROR, rx_q.size() == 1} !== {exp_data, exp_perr, exp_ferr, 1'b1}) begin
      bad++;
      $display("FAIL parity_clear: got data=%h pe=%b fe=%b pulses=%0d want data=%h pe=%b fe=%b pulses=1", Rx_DATA, Rx_PERROR, Rx_FERROR, rx_q.size(), exp_data, exp_perr, exp_ferr);
    end
    rx_q.delete(); exp_q.delete();
  endtask

  task automatic test_framing_glitch();
    int bc = bit_cycles(7);
    send_bits(frame_bits(8'h3C, ^8'h3C, 1'b0), 0, 10, bc);
    model_frame(8'h3C, ^8'h3C, 1'b0);
    // line stays low after the bad stop bit before returning high
    repeat (bc) @(negedge clk);
    idle(bc);
    total++;
    if ({Rx_DATA, Rx_PERROR, Rx_FERROR, rx_q.size() == 0} !== {exp_data, exp_perr, exp_ferr, 1'b1}) begin
      bad++;
      $display("FAIL framing_err: got data=%h pe=%b fe=%b pulses=%0d want data=%h pe=%b fe=%b pulses=0", Rx_DATA, Rx_PERROR, Rx_FERROR, rx_q.size(), exp_data, exp_perr, exp_ferr);
    end
    RxD = 1'b0;
    repeat (100) @(negedge clk);
    idle(2 * bc);
    total++;
    if ({Rx_DATA, Rx_PERROR, Rx_FERROR, rx_q.size() == 0} !== {exp_data, exp_perr, exp_ferr, 1'b1}) begin
      bad++;
      $display("FAIL glitch: got data=%h pe=%b fe=%b pulses=%0d want data=%h pe=%b fe=%b pulses=0", Rx_DATA, Rx_PERROR, Rx_FERROR, rx_q.size(), exp_data, exp_perr, exp_ferr);
    end
    rx_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int bc = bit_cycles(7);
    logic [7:0] seq [3] = '{8'h00, 8'hFF, 8'h55};
    for (int i = 0; i < 3; i++) begin
      send_bits(frame_bits(seq[i], ^seq[i], 1'b1), 0, 10, bc);
      model_frame(seq[i], ^seq[i], 1'b1);
    end
    idle(20);
    total++;
    if (rx_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL b2b_count: got %0d want %0d", rx_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        total++;
        if (rx_q[i] !== exp_q[i]) begin
          bad++;
          $display("FAIL b2b_data[%0d]: got %h want %h", i, rx_q[i], exp_q[i]);
        end
      end
    end
    total++;
    if ({Rx_PERROR, Rx_FERROR, dbl_valid} !== {exp_perr, exp_ferr, 32'd0}) begin
      bad++;
      $display("FAIL b2b_flags: got pe=%b fe=%b long_pulses=%0d want pe=%b fe=%b long_pulses=0", Rx_PERROR, Rx_FERROR, dbl_valid, exp_perr, exp_ferr);
    end
    rx_q.delete(); exp_q.delete();
  endtask

  task automatic test_baud_latch();
    int bc = bit_cycles(6);
    logic [7:0] d = 8'($urandom);
    logic [10:0] bits = frame_bits(d, ^d, 1'b1);
    baud_select = 3'd6;
    send_bits(bits, 0, 0, bc);
    baud_select = 3'd7;
    send_bits(bits, 1, 10, bc);
    model_frame(d, ^d, 1'b1);
    idle(20);
    total++;
    if ({Rx_DATA, Rx_PERROR, Rx_FERROR, rx_q.size() == 1} !== {exp_data, exp_perr, exp_ferr, 1'b1}) begin
      bad++;
      $display("FAIL baud_latch: got data=%h pe=%b fe=%b pulses=%0d want data=%h pe=%b fe=%b pulses=1", Rx_DATA, Rx_PERROR, Rx_FERROR, rx_q.size(), exp_data, exp_perr, exp_ferr);
    end
    rx_q.delete(); exp_q.delete();
  endtask

  task automatic test_rx_enable();
    int bc = bit_cycles(7);
    logic [10:0] bits = frame_bits(8'h81, ^8'h81, 1'b1);
    send_bits(bits, 0, 4, bc);
    RX_EN = 1'b0;
    send_bits(bits, 5, 10, bc);
    idle(bc);
    RX_EN = 1'b1;
    idle(bc);
    total++;
    if ({Rx_DATA, Rx_PERROR, Rx_FERROR, rx_q.size() == 0} !== {exp_data, exp_perr, exp_ferr, 1'b1}) begin
      bad++;
      $display("FAIL rx_en_abort: got data=%h pe=%b fe=%b pulses=%0d want data=%h pe=%b fe=%b pulses=0", Rx_DATA, Rx_PERROR, Rx_FERROR, rx_q.size(), exp_data, exp_perr, exp_ferr);
    end
    send_bits(bits, 0, 10, bc);
    model_frame(8'h81, ^8'h81, 1'b1);
    idle(20);
    total++;
    if ({Rx_DATA, Rx_PERROR, Rx_FERROR, rx_q.size() == 1} !== {exp_data, exp_perr, exp_ferr, 1'b1}) begin
      bad++;
      $display("FAIL rx_en_resume: got data=%h pe=%b fe=%b pulses=%0d want data=%h pe=%b fe=%b pulses=1", Rx_DATA, Rx_PERROR, Rx_FERROR, rx_q.size(), exp_data, exp_perr, exp_ferr);
    end
    rx_q.delete(); exp_q.delete();
  endtask

  task automatic test_midframe_reset();
    int bc = bit_cycles(7);
    send_bits(frame_bits(8'h5A, ^8'h5A, 1'b1), 0, 3, bc);
    #3 reset = 1'b1;
    RxD = 1'b1;
    exp_data = 8'h00; exp_perr = 1'b0; exp_ferr = 1'b0;
    #1;
    total++;
    if ({Rx_DATA, Rx_PERROR, Rx_FERROR, Rx_VALID} !== 11'd0) begin
      bad++;
      $display("FAIL async_reset: got data=%h pe=%b fe=%b v=%b want all zero", Rx_DATA, Rx_PERROR, Rx_FERROR, Rx_VALID);
    end
    repeat (5) @(negedge clk);
    reset = 1'b0;
    idle(bc);
    send_bits(frame_bits(8'h3C, ^8'h3C, 1'b1), 0, 10, bc);
    model_frame(8'h3C, ^8'h3C, 1'b1);
    idle(20);
    total++;
    if ({Rx_DATA, Rx_PERROR, Rx_FERROR, rx_q.size() == 1} !== {exp_data, exp_perr, exp_ferr, 1'b1}) begin
      bad++;
      $display("FAIL after_reset: got data=%h pe=%b fe=%b pulses=%0d want data=%h pe=%b fe=%b pulses=1", Rx_DATA, Rx_PERROR, Rx_FERROR, rx_q.size(), exp_data, exp_perr, exp_ferr);
    end
    rx_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    int bc = bit_cycles(7);
    for (int n = 0; n < 2; n++) begin
      logic [7:0] d = 8'($urandom);
      logic p = (^d) ^ ($urandom_range(0, 3) == 0);
      logic s = ($urandom_range(0, 3) != 0);
      send_bits(frame_bits(d, p, s), 0, 10, bc);
      model_frame(d, p, s);
      idle(bc);
      total++;
      if ({Rx_DATA, Rx_PERROR, Rx_FERROR, rx_q.size()} !== {exp_data, exp_perr, exp_ferr, exp_q.size()}) begin
        bad++;
        $display("FAIL random[%0d]: got data=%h pe=%b fe=%b pulses=%0d want data=%h pe=%b fe=%b pulses=%0d",
                 n, Rx_DATA, Rx_PERROR, Rx_FERROR, rx_q.size(), exp_data, exp_perr, exp_ferr, exp_q.size());
      end
      rx_q.delete(); exp_q.delete();
    end
    total++;
    if (dbl_valid !== 0) begin
      bad++;
      $display("FAIL valid_width: got %0d long pulses want 0", dbl_valid);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity_error();
    test_framing_glitch();
    test_back_to_back();
    test_baud_latch();
    test_rx_enable();
    test_midframe_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, system clock frequency in Hz used for the divisor table.
REQ-002 clk  input  1  system clock; all logic on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 baud_select  input  3  rate code: 0=300, 1=1200, 2=4800, 3=9600, 4=19200, 5=38400, 6=57600, 7=115200 baud.
REQ-005 RX_EN  input  1  receiver enable; low forces idle.
REQ-006 RxD  input  1  serial line, idle high, asynchronous to clk.
REQ-007 Rx_DATA  output  8  last correctly received byte.
REQ-008 Rx_VALID  output  1  one-cycle pulse per error-free frame.
REQ-009 Rx_PERROR  output  1  parity error flag of the last frame.
REQ-010 Rx_FERROR  output  1  framing (stop bit) error flag of the last frame.

Function
REQ-011 Frame format SHALL be: start bit (0), 8 data bits LSB first, even parity bit, 1 stop bit (1).
REQ-012 RxD SHALL pass through a 2-flop synchronizer before any use.
REQ-013 Sample tick SHALL be 16x baud; divisor = round(CLK_FREQ/(16*baud)): 10417, 2604, 651, 326, 163, 81, 54, 27 for codes 0-7 at 50 MHz.
REQ-014 Divider and 4-bit tick counter SHALL restart at start-bit detection so samples fall at tick 8 (bit midpoint) of every bit.
REQ-015 baud_select SHALL be latched at start-bit detection and held constant for the whole frame.
REQ-016 FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-017 IDLE -> START on synchronized RxD 1->0 while RX_EN=1.
REQ-018 START: at tick 8, RxD=0 -> DATA; RxD=1 -> IDLE (false start, no outputs change).
REQ-019 DATA: sample one bit per 16 ticks into shift register LSB first; after 8th sample -> PARITY.
REQ-020 PARITY: sample bit; parity error if XOR of 8 data bits and parity bit is 1; -> STOP.
REQ-021 STOP: sample at tick 8; framing error if sample is 0; -> IDLE immediately (no wait for bit end), allowing back-to-back frames.
REQ-022 On STOP sample, Rx_PERROR and Rx_FERROR SHALL be updated the next cycle and held until next start-bit detection, where both clear.
REQ-023 Error-free frame: Rx_DATA loaded and Rx_VALID high for exactly one clk, the cycle after the STOP sample tick.
REQ-024 Frame with any error: Rx_VALID stays 0, Rx_DATA retains previous value.
REQ-025 RX_EN low in any state SHALL force IDLE within one cycle and discard partial frame; flags and Rx_DATA unchanged.
REQ-026 Framing error with RxD still low: receiver SHALL not restart until RxD returns high (falling edge required).

Reset
REQ-027 reset=1 SHALL asynchronously force: state IDLE, Rx_DATA=0x00, Rx_VALID=0, Rx_PERROR=0, Rx_FERROR=0, counters 0, synchronizer flops 1.
REQ-028 Reset mid-frame SHALL abort the frame; after release receiver waits for a new falling edge.

Verification
REQ-029 Assert reset 100 ns with RxD=1 -> all outputs 0, no Rx_VALID during 20 bit periods idle.
REQ-030 baud 7, 50 MHz clk, bit time 8640 ns; frame 0xA5 parity 0 stop 1 -> one-cycle Rx_VALID, Rx_DATA=0xA5, both flags 0.
REQ-031 Same frame with parity bit 1 -> Rx_PERROR=1, Rx_VALID=0, Rx_DATA still 0xA5 from prior frame; next good frame clears flag.
REQ-032 Frame 0x3C with stop bit 0 -> Rx_FERROR=1, Rx_VALID=0; then 2000 ns low glitch (< half bit) in idle -> no frame, no flag change.
REQ-033 Loopback from uart_transmitter at baud 3: bytes 0x00, 0xFF, 0x55 back-to-back -> three Rx_VALID pulses in order with matching Rx_DATA.
REQ-034 RX_EN dropped after 4th data bit of 0x81 frame, re-raised -> no Rx_VALID; following full 0x81 frame received correctly.
